// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler that shares one toggle engine among N requesters.
// Each grant toggles exactly one bit of the T-FF bank q and returns a one-cycle
// registered ack. A programmable idle gap follows every toggle.
// Optional feature: define TFF_SCHED_CNT_EN to add the toggle_cnt counter port.
module tff_toggle_scheduler #(
  parameter int unsigned N   = 4,
  parameter int unsigned GAP = 1
`ifdef TFF_SCHED_CNT_EN
  ,
  parameter int unsigned CW  = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         q,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
`ifdef TFF_SCHED_CNT_EN
  ,
  output logic [CW-1:0]        toggle_cnt
`endif
);

  localparam int unsigned IdW = $clog2(N);
  // Gap counter counts down from GAP-1; unused when GAP is 0.
  localparam logic [2:0] GapLoad = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  typedef enum logic [1:0] {StIdle, StToggle, StGap} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [2:0]       gap_q, gap_d;
  logic [N-1:0]     eligible;
  logic             found;
  logic [IdW-1:0]   pick;
  int               idx;
`ifdef TFF_SCHED_CNT_EN
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  // Next-state logic: round-robin pick in IDLE, toggle+ack in TOGGLE, countdown in GAP.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ack_d   = '0;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
`ifdef TFF_SCHED_CNT_EN
    cnt_d   = cnt_q;
`endif

    // A requester being acked this cycle is not eligible, so dropping req on ack is safe.
    eligible = req & ~ack_q;
    found    = 1'b0;
    pick     = ptr_q;
    idx      = 0;
    for (int i = 0; i < int'(N); i++) begin
      idx = (int'(ptr_q) + i) % int'(N);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = IdW'(idx);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          state_d = StToggle;
        end
      end
      StToggle: begin
        q_d[grant_q]   = ~q_q[grant_q];
        ack_d[grant_q] = 1'b1;
        ptr_d          = (grant_q == IdW'(N - 1)) ? '0 : grant_q + 1'b1;
`ifdef TFF_SCHED_CNT_EN
        cnt_d          = cnt_q + 1'b1;
`endif
        if (GAP > 0) begin
          state_d = StGap;
          gap_d   = GapLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset discards any pending toggle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
`ifdef TFF_SCHED_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
`ifdef TFF_SCHED_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign q        = q_q;
  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);
`ifdef TFF_SCHED_CNT_EN
  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tff_toggle_scheduler.sv
// Self-checking bench for tff_toggle_scheduler (N=4, GAP=1; CW=2 when TFF_SCHED_CNT_EN).
// A timeline model (grant pending / cycle at which IDLE may sample again) predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_tff_toggle_scheduler;

  localparam int N   = 4;
  localparam int GAP = 1;
  localparam int CW  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic [N-1:0] q;
  logic         busy;
  logic [1:0]   grant_id;
`ifdef TFF_SCHED_CNT_EN
  logic [CW-1:0] toggle_cnt;
`endif

  int tests = 0;
  int fails = 0;

  tff_toggle_scheduler #(
    .N   (N),
    .GAP (GAP)
`ifdef TFF_SCHED_CNT_EN
    ,
    .CW  (CW)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .ack      (ack),
    .q        (q),
    .busy     (busy),
    .grant_id (grant_id)
`ifdef TFF_SCHED_CNT_EN
    ,
    .toggle_cnt (toggle_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           e = 0;        // number of rising edges seen
  logic [N-1:0] mq = '0;
  logic [N-1:0] mack = '0;
  int           mgid = 0;
  int           mptr = 0;
  bit           pending = 0;  // a grant was made, toggle happens at the next edge
  int           pg = 0;
  int           free_at = 0;  // first edge at which an idle scheduler may grant again
  int           mcnt = 0;
  bit           mbusy = 0;

  function automatic int rr_pick(input logic [N-1:0] elig, input int from);
    for (int k = 0; k < N; k++) begin
      if (elig[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Advance the model by one edge using the inputs that were stable before it.
  always @(posedge clk) begin
    logic [N-1:0] prev_ack;
    int           w;
    if (!reset) begin
      mq = '0; mack = '0; mgid = 0; mptr = 0; pending = 0; free_at = e + 1; mcnt = 0;
    end else begin
      prev_ack = mack;
      mack = '0;
      if (pending) begin
        mq[pg]   = ~mq[pg];
        mack[pg] = 1'b1;
        mptr     = (pg + 1) % N;
        mcnt++;
        pending  = 0;
        free_at  = e + 1 + GAP;
      end else if (e >= free_at) begin
        w = rr_pick(req & ~prev_ack, mptr);
        if (w >= 0) begin
          pending = 1;
          pg      = w;
          mgid    = w;
        end
      end
    end
    mbusy = pending || (e + 1 < free_at);
    e++;
  end

  // Compare every cycle, half a period after the edge.
  always @(negedge clk) begin
    if (e > 0) begin
      check("cyc_q", 32'(q), 32'(mq));
      check("cyc_ack", 32'(ack), 32'(mack));
      check("cyc_busy", 32'(busy), 32'(mbusy));
      check("cyc_grant_id", 32'(grant_id), 32'(mgid));
`ifdef TFF_SCHED_CNT_EN
      check("cyc_toggle_cnt", 32'(toggle_cnt), 32'(mcnt % (1 << CW)));
`endif
    end
  end

  // Wait (bounded) for a non-zero ack; returns number of negedges waited.
  task automatic wait_ack(output int cyc, output logic [N-1:0] a);
    cyc = 0;
    a   = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
    if (a == '0) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no ack, expected one within 20 cycles");
    end
  endtask

  initial begin
    int           c;
    logic [N-1:0] a;
    logic [N-1:0] exp_a;

    // 1. reset held low two cycles
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
`ifdef TFF_SCHED_CNT_EN
    check("rst_toggle_cnt", 32'(toggle_cnt), 32'h0);
`endif

    // 2. single request from requester 2
    reset = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    check("t2_busy_toggle", 32'(busy), 32'h1);
    check("t2_grant_id", 32'(grant_id), 32'h2);
    check("t2_ack_early", 32'(ack), 32'h0);
    @(negedge clk);
    check("t2_ack", 32'(ack), 32'h4);
    check("t2_q", 32'(q), 32'h4);
    req = '0;
    @(negedge clk);
    check("t2_ack_pulse", 32'(ack), 32'h0);
    @(negedge clk);
    check("t2_idle", 32'(busy), 32'h0);

    // 3. all four request from reset, each drops on its ack
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_ack(c, a);
      exp_a = 4'b0001 << k;
      check("t3_order", 32'(a), 32'(exp_a));
      check("t3_spacing", 32'(c), (k == 0) ? 32'd2 : 32'd3);
      req = req & ~a;
    end
    check("t3_q", 32'(q), 32'hF);
    check("t3_model_q", 32'(mq), 32'hF);

    // 4. after a grant to 3, requesters 0 and 3 -> 0 first (pointer wrapped)
    req = 4'b1001;
    wait_ack(c, a);
    check("t4_first", 32'(a), 32'h1);
    req = req & ~a;
    wait_ack(c, a);
    check("t4_second", 32'(a), 32'h8);
    req = req & ~a;
    check("t4_q", 32'(q), 32'h6);
    repeat (2) @(negedge clk);

    // 5. reset during TOGGLE discards the toggle
    req = 4'b0010;
    @(negedge clk);
    check("t5_in_toggle", 32'(busy), 32'h1);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    check("t5_ack", 32'(ack), 32'h0);
    check("t5_q", 32'(q), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_no_late_ack", 32'(ack), 32'h0);

`ifdef TFF_SCHED_CNT_EN
    // 6. five grants to requester 1 with a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      req = 4'b0010;
      wait_ack(c, a);
      req = '0;
    end
    repeat (2) @(negedge clk);
    check("t6_toggle_cnt", 32'(toggle_cnt), 32'h1);
    check("t6_q1", 32'(q[1]), 32'h1);
`endif

    // Random phase: requesters hold req until ack, then may re-request; rare resets.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
      end
    end
    reset = 1'b1;
    req   = '0;
    repeat (4) @(negedge clk);
    check("end_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
